// File: rtl/muldiv_unit.sv
// Iterative radix-2 signed/unsigned multiply and restoring divide feeding HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dz_pend;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               last_step;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = cond_neg(a, a_neg);
  assign b_mag     = cond_neg(b, b_neg);

  // Restoring divide step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor};

`ifdef MULDIV_EARLY_OUT_EN
  assign last_step = (cnt == CW'(1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
  assign last_step = (cnt == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_pend  <= 1'b0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still counts as busy, so a start there is ignored.
          if (start && !done) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            prod     <= '0;
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            divisor  <= b_mag;
            quo      <= a_mag;
            cnt      <= CW'(WIDTH);
            if (op[1] && (b == '0)) begin
              dz_pend <= 1'b1;
              rem     <= a;
              state   <= FIX;
            end else begin
              dz_pend <= 1'b0;
              rem     <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= rem_sh[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt - CW'(1);
          if (last_step) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            hi <= rem;
            lo <= '1;
          end else if (is_div) begin
            lo <= cond_neg(quo, neg_res);
            hi <= cond_neg(rem, neg_rem);
          end else begin
            {hi, lo} <= cond_neg2(prod, neg_res);
          end
          state <= DONE;
        end
        DONE: begin
          done     <= 1'b1;
          div_zero <= dz_pend;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model, per-done compare process, literal pins.
`timescale 1ns/1ps
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;
  logic        exp_pending = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference results straight from 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic [63:0]     q;
    logic [63:0]     r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    mdz = 1'b0;
    mh  = '0;
    ml  = '0;
    case (o)
      2'b00: begin p = sx * sy; mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin p = ux * uy; mh = p[63:32]; ml = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          mdz = 1'b1; mh = x; ml = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy; ml = q[31:0]; mh = r[31:0];
        end else begin
          q = ux / uy; r = ux % uy; ml = q[31:0]; mh = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic int exp_edges(input logic [1:0] o, input logic [31:0] y);
    int          n;
    logic [31:0] m;
    if (o[1] && (y == 32'd0)) return 2;
    n = 0;
    m = y;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      if (!o[0] && y[31]) m = -y;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      if (n < 1) n = 1;
      return n + 2;
    end
`endif
    return 34 + n - n + int'(m[0]) - int'(m[0]);
  endfunction

  always @(negedge clk) begin
    if (done) begin
      chk("done_expected", 64'(exp_pending), 64'd1);
      chk("model_hi", 64'(hi), 64'(exp_hi));
      chk("model_lo", 64'(lo), 64'(exp_lo));
      chk("model_div_zero", 64'(div_zero), 64'(exp_dz));
      exp_pending = 1'b0;
    end
  end

  // poke>0: pulse an unrelated start that many edges into the operation.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    int          n;
    logic [31:0] mh, ml;
    logic        mdz;
    model(o, x, y, mh, ml, mdz);
    exp_hi = mh; exp_lo = ml; exp_dz = mdz; exp_pending = 1'b1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 200) begin
      if (n == poke && poke > 0) begin
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (n == 1 && !done) chk("busy_mid", 64'(busy), 64'd1);
    end
    start = 1'b0;
    chk("latency", 64'(n), 64'(exp_edges(o, y)));
    chk("busy_in_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_cleared", 64'(busy), 64'd0);
  endtask

  task automatic lit(input string name, input logic [31:0] eh, input logic [31:0] el, input logic edz);
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
    chk({name, "_dz"}, 64'(div_zero), 64'(edz));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    lit("reset", 32'h0, 32'h0, 1'b0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    lit("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    lit("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    lit("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    lit("divu", 32'd2, 32'd14, 1'b0);
    run_op(2'b11, 32'h64, 32'h0, 0);
    lit("divu_zero", 32'h64, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    lit("mult_minmin", 32'h4000_0000, 32'h0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    lit("div_ovf", 32'h0, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    lit("div_pos_neg", 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    lit("div_neg_neg", 32'hFFFF_FFFF, 32'd3, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'h0, 0);
    lit("div_zero_signed", 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b01, 32'h1234_5678, 32'h0, 0);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
    run_op(2'b00, 32'd6, 32'd7, 5);
    lit("mult_poked", 32'd0, 32'd42, 1'b0);

    // Abort an operation with reset at edge 10.
    op = 2'b00; a = 32'd123; b = 32'd456; start = 1'b1; exp_pending = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1; exp_pending = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    lit("abort", 32'h0, 32'h0, 1'b0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);

    run_op(2'b00, 32'd6, 32'd7, 0);
    lit("mult_after_abort", 32'd0, 32'd42, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
